// File: rtl/lmac_txfifo_pkg.sv
// Shared constants, entry type and pointer helpers for the LMAC TX packet FIFO.
// Pointer helpers take zero-extended 32-bit pointers so one function serves any depth.
package lmac_txfifo_pkg;

    localparam int DEF_DATA_W       = 64;
    localparam int DEF_DEPTH_LOG2   = 5;
    localparam int DEF_USEDW_W      = 13;
    localparam int DEF_AFULL_THRESH = 28;
    localparam int DEF_PKT_CNT_W    = 6;

    typedef struct packed {
        logic                  eop;
        logic [DEF_DATA_W-1:0] data;
    } txfifo_entry_t;

    function automatic int ptr_w(input int depth_log2);
        return depth_log2 + 1;
    endfunction

    // Full when the pointers differ only in the wrap bit.
    function automatic logic ptr_full(input logic [31:0] a, input logic [31:0] b,
                                      input int depth_log2);
        return (a ^ b) == (32'd1 << depth_log2);
    endfunction

    function automatic logic ptr_empty(input logic [31:0] a, input logic [31:0] b);
        return a == b;
    endfunction

endpackage

// File: rtl/lmac_tx_pkt_fifo_if.sv
// Host-write / MAC-read bundle of the TX packet FIFO. master = host/MAC side,
// slave = the FIFO itself.
interface lmac_tx_pkt_fifo_if #(
    parameter int DATA_W    = lmac_txfifo_pkg::DEF_DATA_W,
    parameter int USEDW_W   = lmac_txfifo_pkg::DEF_USEDW_W,
    parameter int PKT_CNT_W = lmac_txfifo_pkg::DEF_PKT_CNT_W
);
    logic                 wr_en;
    logic [DATA_W-1:0]    wr_data;
    logic                 wr_eop;
    logic                 full;
    logic                 almost_full;
    logic [USEDW_W-1:0]   usedw;
    logic                 rd_en;
    logic [DATA_W-1:0]    rd_data;
    logic                 rd_eop;
    logic                 rd_valid;
    logic                 empty;
    logic                 pkt_avail;
    logic [PKT_CNT_W-1:0] pkt_cnt;
    logic                 ovf;

    modport master (
        output wr_en, wr_data, wr_eop, rd_en,
        input  full, almost_full, usedw, rd_data, rd_eop, rd_valid,
               empty, pkt_avail, pkt_cnt, ovf
    );

    modport slave (
        input  wr_en, wr_data, wr_eop, rd_en,
        output full, almost_full, usedw, rd_data, rd_eop, rd_valid,
               empty, pkt_avail, pkt_cnt, ovf
    );
endinterface

// File: rtl/lmac_txfifo_mem.sv
// Simple dual-port entry store with a registered read port; the EOP tag of the
// read address is also exposed combinationally so packet accounting need not wait.
module lmac_txfifo_mem #(
    parameter int WIDTH  = 65,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_data_o,
    output logic              rd_tag_o
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] tag_q;
    logic [WIDTH-1:0] rd_data_q;

    // NOTE: the array has no reset so it maps onto RAM; an entry is only ever
    // read after it has been written.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
            tag_q[wr_addr_i] <= wr_data_i[WIDTH-1];
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;
    assign rd_tag_o  = tag_q[rd_addr_i];

endmodule

// File: rtl/lmac_tx_pkt_fifo.sv
// LMAC TX write-packet FIFO: qword+EOP buffer with packet accounting and overflow pulse.
// Define LMAC_TXFIFO_DROP_PKT_EN for store-and-forward whole-packet drop on overflow.
module lmac_tx_pkt_fifo
    import lmac_txfifo_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int DEPTH_LOG2   = DEF_DEPTH_LOG2,
    parameter int USEDW_W      = DEF_USEDW_W,
    parameter int AFULL_THRESH = DEF_AFULL_THRESH,
    parameter int PKT_CNT_W    = DEF_PKT_CNT_W
) (
    input logic               clk,
    input logic               rst,
    lmac_tx_pkt_fifo_if.slave bus
);
    localparam int PTR_W = ptr_w(DEPTH_LOG2);
    localparam logic [PKT_CNT_W-1:0] PKT_MAX = '1;

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic                 rd_valid_q;
    logic                 ovf_q, ovf_d;
    logic                 full, empty;
    logic                 wr_acc, rd_acc;
    logic                 pkt_inc, pkt_dec;
    logic                 peek_eop;
    logic [PTR_W-1:0]     used;
    logic [DATA_W:0]      rd_entry;

`ifdef LMAC_TXFIFO_DROP_PKT_EN
    logic [PTR_W-1:0]     cmt_ptr_q, cmt_ptr_d;
    logic                 discard_q, discard_d;

    // Only committed (EOP-terminated) packets are visible to the reader.
    assign empty = ptr_empty(32'(cmt_ptr_q), 32'(rd_ptr_q));
`else
    assign empty = ptr_empty(32'(wr_ptr_q), 32'(rd_ptr_q));
`endif

    assign full   = ptr_full(32'(wr_ptr_q), 32'(rd_ptr_q), DEPTH_LOG2);
    assign rd_acc = bus.rd_en && !empty;
    assign used   = wr_ptr_q - rd_ptr_q;

    // NOTE: every always_comb output gets a default first, so no path leaves a latch.
    always_comb begin
        wr_acc   = 1'b0;
        ovf_d    = 1'b0;
        wr_ptr_d = wr_ptr_q;
`ifdef LMAC_TXFIFO_DROP_PKT_EN
        cmt_ptr_d = cmt_ptr_q;
        discard_d = discard_q;
        if (bus.wr_en) begin
            if (discard_q) begin
                if (bus.wr_eop) discard_d = 1'b0;
            end else if (full) begin
                // Throw away the partial packet; a dropped EOP word already ends it.
                ovf_d     = 1'b1;
                wr_ptr_d  = cmt_ptr_q;
                discard_d = !bus.wr_eop;
            end else begin
                wr_acc   = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (bus.wr_eop) cmt_ptr_d = wr_ptr_q + 1'b1;
            end
        end
`else
        if (bus.wr_en) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                wr_acc   = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
        end
`endif
    end

    assign pkt_inc = wr_acc && bus.wr_eop;
    assign pkt_dec = rd_acc && peek_eop;

    always_comb begin
        rd_ptr_d  = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
        pkt_cnt_d = pkt_cnt_q;
        if (pkt_inc && !pkt_dec && pkt_cnt_q != PKT_MAX) begin
            pkt_cnt_d = pkt_cnt_q + 1'b1;
        end else if (pkt_dec && !pkt_inc && pkt_cnt_q != '0) begin
            pkt_cnt_d = pkt_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pkt_cnt_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pkt_cnt_q  <= pkt_cnt_d;
            rd_valid_q <= rd_acc;
            ovf_q      <= ovf_d;
        end
    end

`ifdef LMAC_TXFIFO_DROP_PKT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cmt_ptr_q <= '0;
            discard_q <= 1'b0;
        end else begin
            cmt_ptr_q <= cmt_ptr_d;
            discard_q <= discard_d;
        end
    end
`endif

    lmac_txfifo_mem #(
        .WIDTH  (DATA_W + 1),
        .ADDR_W (DEPTH_LOG2)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
        .wr_data_i ({bus.wr_eop, bus.wr_data}),
        .rd_en_i   (rd_acc),
        .rd_addr_i (rd_ptr_q[DEPTH_LOG2-1:0]),
        .rd_data_o (rd_entry),
        .rd_tag_o  (peek_eop)
    );

    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.usedw       = USEDW_W'(used);
    assign bus.almost_full = 32'(used) >= AFULL_THRESH;
    assign bus.rd_data     = rd_entry[DATA_W-1:0];
    assign bus.rd_eop      = rd_entry[DATA_W];
    assign bus.rd_valid    = rd_valid_q;
    assign bus.pkt_cnt     = pkt_cnt_q;
    assign bus.pkt_avail   = pkt_cnt_q != '0;
    assign bus.ovf         = ovf_q;

endmodule

// File: tb/tb_lmac_tx_pkt_fifo.sv
// Self-checking bench for lmac_tx_pkt_fifo: directed scenarios plus randomized traffic
// against a queue-based packet model (honours LMAC_TXFIFO_DROP_PKT_EN).
module tb_lmac_tx_pkt_fifo;
    import lmac_txfifo_pkg::*;

    localparam int DEPTH   = 1 << DEF_DEPTH_LOG2;
    localparam int PKT_MAX = (1 << DEF_PKT_CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lmac_tx_pkt_fifo_if bus ();

    lmac_tx_pkt_fifo dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: readable entries, uncommitted tail, discard flag, registered read outputs.
    txfifo_entry_t m_q[$];
    txfifo_entry_t m_pend[$];
    bit            m_discard;
    int            m_pkts;
    logic [63:0]   m_rd_data;
    logic          m_rd_eop;
    logic          m_rd_valid;
    logic          m_ovf;

    function automatic logic [24:0] exp_status();
        int occ = m_q.size() + m_pend.size();
        return {occ == DEPTH, occ >= DEF_AFULL_THRESH, m_q.size() == 0, m_pkts != 0,
                m_rd_valid, m_ovf, 13'(occ), 6'(m_pkts)};
    endfunction

    function automatic logic [24:0] dut_status();
        return {bus.full, bus.almost_full, bus.empty, bus.pkt_avail, bus.rd_valid,
                bus.ovf, bus.usedw, bus.pkt_cnt};
    endfunction

    // Apply one cycle of inputs, advance the model across the edge, settle #1 after it.
    task automatic step(input logic r, input logic we, input logic [63:0] wd,
                        input logic weop, input logic re);
        txfifo_entry_t e;
        bit full_now;
        rst         = r;
        bus.wr_en   = we;
        bus.wr_data = wd;
        bus.wr_eop  = weop;
        bus.rd_en   = re;
        @(posedge clk);
        full_now = (m_q.size() + m_pend.size()) == DEPTH;
        if (r) begin
            m_q.delete();
            m_pend.delete();
            m_discard  = 1'b0;
            m_pkts     = 0;
            m_rd_data  = '0;
            m_rd_eop   = 1'b0;
            m_rd_valid = 1'b0;
            m_ovf      = 1'b0;
        end else begin
            m_ovf      = 1'b0;
            m_rd_valid = 1'b0;
            if (re && m_q.size() != 0) begin
                e          = m_q.pop_front();
                m_rd_data  = e.data;
                m_rd_eop   = e.eop;
                m_rd_valid = 1'b1;
                if (e.eop && m_pkts > 0) m_pkts--;
            end
            if (we) begin
`ifdef LMAC_TXFIFO_DROP_PKT_EN
                if (m_discard) begin
                    if (weop) m_discard = 1'b0;
                end else if (full_now) begin
                    m_pend.delete();
                    m_discard = !weop;
                    m_ovf     = 1'b1;
                end else begin
                    m_pend.push_back('{eop: weop, data: wd});
                    if (weop) begin
                        while (m_pend.size() != 0) m_q.push_back(m_pend.pop_front());
                        if (m_pkts < PKT_MAX) m_pkts++;
                    end
                end
`else
                if (full_now) begin
                    m_ovf = 1'b1;
                end else begin
                    m_q.push_back('{eop: weop, data: wd});
                    if (weop && m_pkts < PKT_MAX) m_pkts++;
                end
`endif
            end
        end
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        if (dut_status() !== {1'b0, 1'b0, 1'b1, 3'b000, 13'd0, 6'd0}) begin
            errors++;
            $display("FAIL reset_status: got %h want %h", dut_status(),
                     {1'b0, 1'b0, 1'b1, 3'b000, 13'd0, 6'd0});
        end
        checks++;
        if ({bus.rd_eop, bus.rd_data} !== 65'd0) begin
            errors++;
            $display("FAIL reset_rd_data: got %h want 0", {bus.rd_eop, bus.rd_data});
        end
        checks++;
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        if (dut_status() !== exp_status()) begin
            errors++;
            $display("FAIL reset_idle_read: got %h want %h", dut_status(), exp_status());
        end
        checks++;
    endtask

    task automatic test_basic_packet();
        logic [63:0] d [3];
        do_reset();
        for (int i = 0; i < 3; i++) begin
            d[i] = {$urandom, $urandom};
            step(1'b0, 1'b1, d[i], i == 2, 1'b0);
        end
        if ({bus.usedw, bus.pkt_cnt, bus.pkt_avail, bus.empty} !== {13'd3, 6'd1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL basic_after_write: got usedw=%0d cnt=%0d avail=%b empty=%b want 3 1 1 0",
                     bus.usedw, bus.pkt_cnt, bus.pkt_avail, bus.empty);
        end
        checks++;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, '0, 1'b0, 1'b1);
            if ({bus.rd_valid, bus.rd_eop, bus.rd_data} !== {1'b1, i == 2, d[i]}) begin
                errors++;
                $display("FAIL basic_read%0d: got v=%b eop=%b %h want v=1 eop=%b %h",
                         i, bus.rd_valid, bus.rd_eop, bus.rd_data, i == 2, d[i]);
            end
            checks++;
        end
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        if ({bus.rd_valid, bus.rd_data, bus.empty, bus.pkt_cnt} !== {1'b0, d[2], 1'b1, 6'd0}) begin
            errors++;
            $display("FAIL basic_hold: got v=%b %h empty=%b cnt=%0d want v=0 %h empty=1 cnt=0",
                     bus.rd_valid, bus.rd_data, bus.empty, bus.pkt_cnt, d[2]);
        end
        checks++;
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            step(1'b0, 1'b1, {$urandom, $urandom}, (k % 8) == 7, 1'b0);
            if ({bus.usedw, bus.almost_full, bus.full} !== {13'(k + 1), k + 1 >= 28, k == DEPTH - 1}) begin
                errors++;
                $display("FAIL fill_%0d: got usedw=%0d af=%b full=%b", k, bus.usedw,
                         bus.almost_full, bus.full);
            end
            checks++;
        end
        step(1'b0, 1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
        if ({bus.ovf, bus.full, bus.usedw} !== {1'b1, 1'b1, 13'd32}) begin
            errors++;
            $display("FAIL overflow_write: got ovf=%b full=%b usedw=%0d want 1 1 32",
                     bus.ovf, bus.full, bus.usedw);
        end
        checks++;
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        if ({bus.ovf, bus.usedw} !== {1'b0, 13'd32}) begin
            errors++;
            $display("FAIL overflow_pulse_end: got ovf=%b usedw=%0d want 0 32", bus.ovf, bus.usedw);
        end
        checks++;
    endtask

    task automatic test_full_simul();
        do_reset();
        for (int k = 0; k < DEPTH; k++) step(1'b0, 1'b1, {$urandom, $urandom}, (k % 8) == 7, 1'b0);
        step(1'b0, 1'b1, {$urandom, $urandom}, 1'b1, 1'b1);
        if ({bus.ovf, bus.usedw, bus.rd_valid} !== {1'b1, 13'd31, 1'b1}) begin
            errors++;
            $display("FAIL full_simul: got ovf=%b usedw=%0d v=%b want 1 31 1",
                     bus.ovf, bus.usedw, bus.rd_valid);
        end
        checks++;
        for (int k = 0; k < DEPTH; k++) begin
            step(1'b0, 1'b0, '0, 1'b0, 1'b1);
            if ({dut_status(), bus.rd_eop, bus.rd_data} !== {exp_status(), m_rd_eop, m_rd_data}) begin
                errors++;
                $display("FAIL full_drain_%0d: got %h/%h want %h/%h", k, dut_status(),
                         bus.rd_data, exp_status(), m_rd_data);
            end
            checks++;
        end
        // Read of an empty FIFO alongside a write: no fall-through.
        step(1'b0, 1'b1, {$urandom, $urandom}, 1'b1, 1'b1);
        if ({bus.rd_valid, bus.usedw, bus.empty} !== {1'b0, 13'd1, 1'b0}) begin
            errors++;
            $display("FAIL empty_rd_with_wr: got v=%b usedw=%0d empty=%b want 0 1 0",
                     bus.rd_valid, bus.usedw, bus.empty);
        end
        checks++;
    endtask

    task automatic test_stream_wrap();
        do_reset();
        for (int k = 0; k < 16; k++) step(1'b0, 1'b1, {$urandom, $urandom}, (k % 4) == 3, 1'b0);
        for (int k = 0; k < 100; k++) begin
            step(1'b0, 1'b1, {$urandom, $urandom}, (k % 4) == 3, 1'b1);
            if ({bus.usedw, bus.rd_valid, bus.rd_eop, bus.rd_data} !==
                {13'd16, 1'b1, m_rd_eop, m_rd_data}) begin
                errors++;
                $display("FAIL stream_%0d: got usedw=%0d v=%b %h want 16 1 %h", k,
                         bus.usedw, bus.rd_valid, bus.rd_data, m_rd_data);
            end
            checks++;
        end
    endtask

    task automatic test_random();
        int wr_pct = 50;
        int rd_pct = 50;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) begin
                wr_pct = $urandom_range(20, 95);
                rd_pct = $urandom_range(20, 95);
            end
            step($urandom_range(0, 399) == 0, $urandom_range(0, 99) < wr_pct,
                 {$urandom, $urandom}, $urandom_range(0, 3) == 0, $urandom_range(0, 99) < rd_pct);
            if (dut_status() !== exp_status()) begin
                errors++;
                $display("FAIL random_status_%0d: got %h want %h", i, dut_status(), exp_status());
            end
            checks++;
            if ({bus.rd_eop, bus.rd_data} !== {m_rd_eop, m_rd_data}) begin
                errors++;
                $display("FAIL random_data_%0d: got %b/%h want %b/%h", i, bus.rd_eop,
                         bus.rd_data, m_rd_eop, m_rd_data);
            end
            checks++;
        end
    endtask

`ifdef LMAC_TXFIFO_DROP_PKT_EN
    task automatic test_drop_pkt();
        logic [63:0] d [4];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            d[i] = {$urandom, $urandom};
            step(1'b0, 1'b1, d[i], i == 3, 1'b0);
        end
        for (int j = 0; j < 30; j++) begin
            step(1'b0, 1'b1, {$urandom, $urandom}, j == 29, 1'b0);
            if (j >= 27 && {bus.ovf, bus.usedw} !== {j == 28, (j == 27) ? 13'd32 : 13'd4}) begin
                errors++;
                $display("FAIL drop_word_%0d: got ovf=%b usedw=%0d", j, bus.ovf, bus.usedw);
            end
            if (j >= 27) checks++;
        end
        if ({bus.usedw, bus.pkt_cnt, bus.empty} !== {13'd4, 6'd1, 1'b0}) begin
            errors++;
            $display("FAIL drop_after: got usedw=%0d cnt=%0d empty=%b want 4 1 0",
                     bus.usedw, bus.pkt_cnt, bus.empty);
        end
        checks++;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, '0, 1'b0, 1'b1);
            if ({bus.rd_valid, bus.rd_eop, bus.rd_data} !== {1'b1, i == 3, d[i]}) begin
                errors++;
                $display("FAIL drop_read%0d: got v=%b eop=%b %h want %h", i,
                         bus.rd_valid, bus.rd_eop, bus.rd_data, d[i]);
            end
            checks++;
        end
        if ({bus.empty, bus.usedw, bus.pkt_cnt} !== {1'b1, 13'd0, 6'd0}) begin
            errors++;
            $display("FAIL drop_drained: got empty=%b usedw=%0d cnt=%0d want 1 0 0",
                     bus.empty, bus.usedw, bus.pkt_cnt);
        end
        checks++;
    endtask
`endif

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1, {$urandom, $urandom}, k == 4, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 1'b1, {$urandom, $urandom}, 1'b1, 1'b1);
        if ({bus.usedw, bus.empty, bus.pkt_cnt, bus.rd_valid, bus.ovf, bus.rd_data} !==
            {13'd0, 1'b1, 6'd0, 1'b0, 1'b0, 64'd0}) begin
            errors++;
            $display("FAIL reset_mid: got usedw=%0d empty=%b cnt=%0d v=%b ovf=%b data=%h",
                     bus.usedw, bus.empty, bus.pkt_cnt, bus.rd_valid, bus.ovf, bus.rd_data);
        end
        checks++;
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        if (dut_status() !== exp_status()) begin
            errors++;
            $display("FAIL reset_mid_after: got %h want %h", dut_status(), exp_status());
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_basic_packet();
        test_fill_overflow();
        test_full_simul();
        test_stream_wrap();
`ifdef LMAC_TXFIFO_DROP_PKT_EN
        test_drop_pkt();
`endif
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
